load_store_unit: RTL and testbench

//  Initiator side of the memory_system request/ready interface. Accepts one load or

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Word-addressed memory port between the load/store unit and memory_system.
// The LSU drives requests as master; the memory answers as slave.
interface load_store_unit_if #(
  parameter int DW = 32
);
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_write_en;
  logic          mem_read_en;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_write_en,
    output mem_read_en,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_write_en,
    input  mem_read_en,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: lane extract, sign extension,
// and optional read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit RMW_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid,
  input  logic                  lsu_we,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [31:0]           lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_misaligned,
  load_store_unit_if.master     mem
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      st, st_n;
  req_t        req, req_n;
  logic        mis, mis_n;
  logic [31:0] rdata_n;
  logic [31:0] addr_n;
  logic [31:0] wdata_n;
  logic [3:0]  wen_n;
  logic        ren_n;
  logic        mis_a;
  logic [3:0]  mask_a;
  logic [31:0] rep_a;
  logic [31:0] sh;
  logic [31:0] ld_val;
  logic [31:0] mg;

  assign lsu_busy       = (st == RD) || (st == WR);
  assign lsu_done       = (st == RESP);
  assign lsu_misaligned = lsu_done & mis;

  // Decode the incoming request: alignment, byte mask, lane-replicated data
  always_comb begin
    mis_a  = ((lsu_size == 2'd1) && lsu_addr[0]) ||
             (lsu_size[1] && (|lsu_addr[1:0]));
    mask_a = 4'hF;
    rep_a  = lsu_wdata;
    unique case (1'b1)
      lsu_size == 2'd0: begin
        mask_a = 4'b0001 << lsu_addr[1:0];
        rep_a  = {4{lsu_wdata[7:0]}};
      end
      lsu_size == 2'd1: begin
        mask_a = 4'b0011 << lsu_addr[1:0];
        rep_a  = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = mem.mem_rdata >> {req.addr[1:0], 3'b000};

  // Extract the addressed lane and extend it to a full word
  always_comb begin
    ld_val = mem.mem_rdata;
    unique case (1'b1)
      req.size == 2'd0:
        ld_val = req.uns ? {24'b0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
      req.size == 2'd1:
        ld_val = req.uns ? {16'b0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  // Splice the store byte/half into the word just read back
  always_comb begin
    mg = mem.mem_rdata;
    if (req.size == 2'd0)
      mg[{req.addr[1:0], 3'b000} +: 8] = req.wdata[7:0];
    else
      mg[{req.addr[1], 4'b0000} +: 16] = req.wdata[15:0];
  end

  // Next state plus next values of every registered output
  always_comb begin
    st_n    = st;
    req_n   = req;
    mis_n   = mis;
    rdata_n = lsu_rdata;
    addr_n  = mem.mem_addr;
    wdata_n = mem.mem_wdata;
    wen_n   = mem.mem_write_en;
    ren_n   = mem.mem_read_en;
    unique case (st)
      IDLE: begin
        if (lsu_valid) begin
          req_n = '{we: lsu_we, size: lsu_size,
                    uns: lsu_unsigned, addr: lsu_addr,
                    wdata: lsu_wdata};
          mis_n = mis_a;
          if (mis_a) begin
            st_n = RESP;
          end else begin
            addr_n = {lsu_addr[31:2], 2'b00};
            if (lsu_we && (lsu_size[1] || !RMW_EN)) begin
              st_n    = WR;
              wen_n   = mask_a;
              wdata_n = rep_a;
            end else begin
              st_n  = RD;
              ren_n = 1'b1;
            end
          end
        end
      end
      RD: begin
        if (mem.mem_ready) begin
          ren_n = 1'b0;
          if (req.we) begin
            st_n    = WR;
            wdata_n = mg;
            wen_n   = 4'hF;
          end else begin
            st_n    = RESP;
            rdata_n = ld_val;
            addr_n  = '0;
          end
        end
      end
      WR: begin
        if (mem.mem_ready) begin
          st_n    = RESP;
          wen_n   = 4'h0;
          wdata_n = '0;
          addr_n  = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st               <= IDLE;
      req              <= '0;
      mis              <= 1'b0;
      lsu_rdata        <= '0;
      mem.mem_addr     <= '0;
      mem.mem_wdata    <= '0;
      mem.mem_write_en <= 4'h0;
      mem.mem_read_en  <= 1'b0;
    end else begin
      st               <= st_n;
      req              <= req_n;
      mis              <= mis_n;
      lsu_rdata        <= rdata_n;
      mem.mem_addr     <= addr_n;
      mem.mem_wdata    <= wdata_n;
      mem.mem_write_en <= wen_n;
      mem.mem_read_en  <= ren_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one RMW instance, one direct-mask
// instance, each on its own two-wait-cycle memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        i_we = 1'b0, i_u = 1'b0;
  logic [1:0]  i_sz = 2'd0;
  logic [31:0] i_a = '0, i_wd = '0;

  logic        o_busy0, o_done0, o_mis0;
  logic        o_busy1, o_done1, o_mis1;
  logic [31:0] o_rd0, o_rd1;

  int checks = 0;
  int errors = 0;

  load_store_unit_if m0 ();
  load_store_unit_if m1 ();

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .RMW_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .lsu_valid(v0), .lsu_we(i_we),
    .lsu_size(i_sz), .lsu_unsigned(i_u), .lsu_addr(i_a),
    .lsu_wdata(i_wd), .lsu_busy(o_busy0), .lsu_done(o_done0),
    .lsu_rdata(o_rd0), .lsu_misaligned(o_mis0), .mem(m0)
  );

  load_store_unit #(.DATA_WIDTH(32), .RMW_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .lsu_valid(v1), .lsu_we(i_we),
    .lsu_size(i_sz), .lsu_unsigned(i_u), .lsu_addr(i_a),
    .lsu_wdata(i_wd), .lsu_busy(o_busy1), .lsu_done(o_done1),
    .lsu_rdata(o_rd1), .lsu_misaligned(o_mis1), .mem(m1)
  );

  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];
  int          c0 = 0, c1 = 0;
  int          nrd0 = 0, nwr0 = 0, nrd1 = 0, nwr1 = 0;
  logic [3:0]  lwe0 = '0, lwe1 = '0;
  logic [31:0] lwd0 = '0, lwd1 = '0;
  int          viol = 0;
  logic        pr0 = 0, pw0 = 0, pr1 = 0, pw1 = 0;

  // Memory 0: ready pulses in the third cycle of a request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0 <= 0;
      m0.mem_ready <= 1'b0;
      m0.mem_rdata <= '0;
    end else if (m0.mem_ready) begin
      m0.mem_ready <= 1'b0;
    end else if (m0.mem_read_en || (|m0.mem_write_en)) begin
      if (c0 == 1) begin
        c0 <= 0;
        m0.mem_ready <= 1'b1;
        m0.mem_rdata <= mem0[m0.mem_addr[7:2]];
        if (m0.mem_read_en) nrd0 <= nrd0 + 1;
        if (|m0.mem_write_en) begin
          nwr0 <= nwr0 + 1;
          lwe0 <= m0.mem_write_en;
          lwd0 <= m0.mem_wdata;
          for (int b = 0; b < 4; b++)
            if (m0.mem_write_en[b])
              mem0[m0.mem_addr[7:2]][8*b +: 8] <= m0.mem_wdata[8*b +: 8];
        end
      end else begin
        c0 <= c0 + 1;
      end
    end
  end

  // Memory 1: same timing as memory 0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= 0;
      m1.mem_ready <= 1'b0;
      m1.mem_rdata <= '0;
    end else if (m1.mem_ready) begin
      m1.mem_ready <= 1'b0;
    end else if (m1.mem_read_en || (|m1.mem_write_en)) begin
      if (c1 == 1) begin
        c1 <= 0;
        m1.mem_ready <= 1'b1;
        m1.mem_rdata <= mem1[m1.mem_addr[7:2]];
        if (m1.mem_read_en) nrd1 <= nrd1 + 1;
        if (|m1.mem_write_en) begin
          nwr1 <= nwr1 + 1;
          lwe1 <= m1.mem_write_en;
          lwd1 <= m1.mem_wdata;
          for (int b = 0; b < 4; b++)
            if (m1.mem_write_en[b])
              mem1[m1.mem_addr[7:2]][8*b +: 8] <= m1.mem_wdata[8*b +: 8];
        end
      end else begin
        c1 <= c1 + 1;
      end
    end
  end

  // A strobe still high the cycle after its ready would restart memory
  always @(negedge clk) begin
    if (pr0 && m0.mem_read_en) viol = viol + 1;
    if (pw0 && (|m0.mem_write_en)) viol = viol + 1;
    if (pr1 && m1.mem_read_en) viol = viol + 1;
    if (pw1 && (|m1.mem_write_en)) viol = viol + 1;
    pr0 = m0.mem_ready && m0.mem_read_en;
    pw0 = m0.mem_ready && (|m0.mem_write_en);
    pr1 = m1.mem_ready && m1.mem_read_en;
    pw1 = m1.mem_ready && (|m1.mem_write_en);
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; count edges until lsu_done
  task automatic op(input bit d, input bit we, input logic [1:0] sz,
                    input bit u, input logic [31:0] a, input logic [31:0] wd,
                    output int lat, output logic mis, output logic [31:0] rd);
    i_we = we; i_sz = sz; i_u = u; i_a = a; i_wd = wd;
    if (d) v1 = 1'b1; else v0 = 1'b1;
    lat = -1; mis = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (d ? (o_busy1 || o_done1) : (o_busy0 || o_done0)) begin
        v0 = 1'b0; v1 = 1'b0;
      end
      if (d ? o_done1 : o_done0) begin
        lat = k;
        mis = d ? o_mis1 : o_mis0;
        rd  = d ? o_rd1 : o_rd0;
        break;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  typedef struct {
    bit          d;
    bit          we;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    bit          mis;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
    logic [3:0]  wen;
    logic [31:0] wdx;
  } vec_t;

  vec_t v[22];

  initial begin
    int          lat, seen, r0, w0, r1, w1;
    logic        mis;
    logic [31:0] rd;

    //      d we sz    u addr       wdata         lat mis rdata       rd wr wen   wdata
    v[0]  = '{0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 4, 0, 32'h0,       0, 1, 4'hF, 32'hDEADBEEF};
    v[1]  = '{0, 0, 2'd2, 0, 32'h10, 32'h0,        4, 0, 32'hDEADBEEF, 1, 0, 4'h0, 32'h0};
    v[2]  = '{0, 0, 2'd0, 0, 32'h13, 32'h0,        4, 0, 32'hFFFFFFDE, 1, 0, 4'h0, 32'h0};
    v[3]  = '{0, 0, 2'd0, 1, 32'h13, 32'h0,        4, 0, 32'h000000DE, 1, 0, 4'h0, 32'h0};
    v[4]  = '{0, 0, 2'd1, 0, 32'h12, 32'h0,        4, 0, 32'hFFFFDEAD, 1, 0, 4'h0, 32'h0};
    v[5]  = '{0, 0, 2'd1, 1, 32'h10, 32'h0,        4, 0, 32'h0000BEEF, 1, 0, 4'h0, 32'h0};
    v[6]  = '{0, 1, 2'd0, 0, 32'h11, 32'h00000055, 7, 0, 32'h0000BEEF, 1, 1, 4'hF, 32'hDEAD55EF};
    v[7]  = '{0, 0, 2'd2, 0, 32'h10, 32'h0,        4, 0, 32'hDEAD55EF, 1, 0, 4'h0, 32'h0};
    v[8]  = '{0, 0, 2'd2, 0, 32'h11, 32'h0,        1, 1, 32'hDEAD55EF, 0, 0, 4'h0, 32'h0};
    v[9]  = '{0, 0, 2'd1, 0, 32'h13, 32'h0,        1, 1, 32'hDEAD55EF, 0, 0, 4'h0, 32'h0};
    v[10] = '{0, 1, 2'd0, 0, 32'h12, 32'hFFFFFF77, 7, 0, 32'hDEAD55EF, 1, 1, 4'hF, 32'hDE7755EF};
    v[11] = '{0, 0, 2'd1, 1, 32'h12, 32'h0,        4, 0, 32'h0000DE77, 1, 0, 4'h0, 32'h0};
    v[12] = '{0, 1, 2'd1, 0, 32'h12, 32'h0000CAFE, 7, 0, 32'h0000DE77, 1, 1, 4'hF, 32'hCAFE55EF};
    v[13] = '{0, 0, 2'd2, 0, 32'h10, 32'h0,        4, 0, 32'hCAFE55EF, 1, 0, 4'h0, 32'h0};
    v[14] = '{1, 1, 2'd2, 0, 32'h20, 32'h0,        4, 0, 32'h0,       0, 1, 4'hF, 32'h0};
    v[15] = '{1, 1, 2'd1, 0, 32'h22, 32'h00001234, 4, 0, 32'h0,       0, 1, 4'hC, 32'h12341234};
    v[16] = '{1, 0, 2'd2, 0, 32'h20, 32'h0,        4, 0, 32'h12340000, 1, 0, 4'h0, 32'h0};
    v[17] = '{1, 1, 2'd0, 0, 32'h23, 32'h000000AB, 4, 0, 32'h12340000, 0, 1, 4'h8, 32'hABABABAB};
    v[18] = '{1, 0, 2'd3, 0, 32'h20, 32'h0,        4, 0, 32'hAB340000, 1, 0, 4'h0, 32'h0};
    v[19] = '{1, 0, 2'd0, 0, 32'h23, 32'h0,        4, 0, 32'hFFFFFFAB, 1, 0, 4'h0, 32'h0};
    v[20] = '{1, 1, 2'd3, 0, 32'h22, 32'h0,        1, 1, 32'hFFFFFFAB, 0, 0, 4'h0, 32'h0};
    v[21] = '{1, 1, 2'd1, 0, 32'h21, 32'h0,        1, 1, 32'hFFFFFFAB, 0, 0, 4'h0, 32'h0};

    @(negedge clk);
    chk("reset_out0", {o_busy0, o_done0, o_mis0, o_rd0, m0.mem_addr,
        m0.mem_wdata, m0.mem_write_en, m0.mem_read_en}, 128'h0);
    chk("reset_out1", {o_busy1, o_done1, o_mis1, o_rd1, m1.mem_addr,
        m1.mem_wdata, m1.mem_write_en, m1.mem_read_en}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      r0 = nrd0; w0 = nwr0; r1 = nrd1; w1 = nwr1;
      op(v[i].d, v[i].we, v[i].sz, v[i].u, v[i].a, v[i].wd, lat, mis, rd);
      @(negedge clk);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_misaligned", i), mis, v[i].mis);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d_reads", i),
          v[i].d ? nrd1 - r1 : nrd0 - r0, v[i].nrd);
      chk($sformatf("v%0d_writes", i),
          v[i].d ? nwr1 - w1 : nwr0 - w0, v[i].nwr);
      if (v[i].nwr > 0) begin
        chk($sformatf("v%0d_wen", i), v[i].d ? lwe1 : lwe0, v[i].wen);
        chk($sformatf("v%0d_wdata", i), v[i].d ? lwd1 : lwd0, v[i].wdx);
      end
    end

    // Request held through the done cycle is taken one cycle later
    op(1'b0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, mis, rd);
    chk("b2b_first_lat", lat, 4);
    chk("b2b_first_rd", rd, 32'h0000CAFE);
    op(1'b0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat, mis, rd);
    chk("b2b_second_lat", lat, 5);
    chk("b2b_second_rd", rd, 32'h00000055);
    @(negedge clk);

    // Input changes and valid strobes while busy are ignored
    r0 = nrd0; w0 = nwr0;
    fork
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, mis, rd);
      begin
        @(posedge clk);
        @(negedge clk);
        #2;
        v0 = 1'b1; i_we = 1'b1; i_sz = 2'd0; i_a = 32'h13; i_wd = 32'h99;
        @(negedge clk);
        #2;
        v0 = 1'b0; i_we = 1'b0; i_sz = 2'd2; i_a = 32'h10; i_wd = 32'h0;
      end
    join
    chk("busy_drop_lat", lat, 4);
    chk("busy_drop_rd", rd, 32'hCAFE55EF);
    repeat (4) @(negedge clk);
    chk("busy_drop_reads", nrd0 - r0, 1);
    chk("busy_drop_writes", nwr0 - w0, 0);
    chk("busy_drop_idle", o_busy0, 1'b0);

    // Reset in the middle of a load
    i_we = 1'b0; i_sz = 2'd2; i_u = 1'b0; i_a = 32'h10;
    v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    chk("pre_reset_busy", o_busy0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_out0", {o_busy0, o_done0, o_mis0, o_rd0, m0.mem_addr,
        m0.mem_wdata, m0.mem_write_en, m0.mem_read_en}, 128'h0);
    chk("midop_reset_out1", {o_busy1, o_done1, o_mis1, o_rd1, m1.mem_addr,
        m1.mem_wdata, m1.mem_write_en, m1.mem_read_en}, 128'h0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done0) seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (o_done0 || o_busy0) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    op(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, mis, rd);
    chk("post_reset_lat", lat, 4);
    chk("post_reset_rd", rd, 32'hCAFE55EF);
    @(negedge clk);

    chk("strobe_drop_after_ready", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
